// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 8-requester round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_arb_pkg;

  localparam int N_REQ           = 8;
  localparam int IDX_W           = 3;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb_8to3_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until granted; done releases the owner.
interface rr_arb_8to3_if;
  import rr_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic             gnt_vld;
  logic [IDX_W-1:0] gnt_idx;
  logic [N_REQ-1:0] gnt_oh;
  logic             timeout;

  modport master (
    output req, done,
    input  gnt_vld, gnt_idx, gnt_oh, timeout
  );

  modport slave (
    input  req, done,
    output gnt_vld, gnt_idx, gnt_oh, timeout
  );

endinterface

// File: rtl/rr_prio_enc8.sv
// Picks the first set request at or above ptr, wrapping 7->0.
// Latency: combinational.
// Backpressure: none; any=0 when no request is set.
module rr_prio_enc8
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W-1:0] src;

  // Rotate so ptr sits at bit 0, then find the lowest set bit of the rotated vector.
  always_comb begin
    rot = '0;
    off = '0;
    src = '0;
    for (int i = 0; i < N_REQ; i++) begin
      src    = ptr + IDX_W'(i);
      rot[i] = req[src];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  // Un-rotate: the offset is relative to ptr and wraps naturally in 3 bits.
  assign idx = ptr + off;
  assign any = |req;

endmodule

// File: rtl/rr_arb_8to3.sv
// Round-robin 8-way arbiter with registered one-hot and binary grant.
// Latency: request to grant 1 cycle; one idle turnaround cycle after each release.
// Backpressure: owner holds until done, req drop or (with RR_ARB_TIMEOUT_EN) forced release.
module rr_arb_8to3
  import rr_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arb_8to3_if.slave  arb
);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt_idx_q;
  logic [N_REQ-1:0] gnt_oh_q;
  logic             timeout_q;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic             rel_norm;
  logic             to_hit;

  // Hold limit must fit the 8-bit counter and leave room for at least one extra cycle.
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout_cyc
    $error("rr_arb_8to3: TIMEOUT_CYC out of range 2..255");
  end

  rr_prio_enc8 u_enc (
    .req (arb.req),
    .ptr (ptr),
    .idx (sel_idx),
    .any (sel_any)
  );

  // A voluntary release (done or request withdrawn) always wins over the timeout.
  assign rel_norm = arb.done | ~arb.req[gnt_idx_q];

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;

  // Count cycles spent in GRANT; IDLE clears it so each grant starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state == GRANT) begin
      hold_cnt <= hold_cnt + 8'd1;
    end else begin
      hold_cnt <= '0;
    end
  end

  assign to_hit = (state == GRANT) && (hold_cnt == 8'(TIMEOUT_CYC - 1));
`else
  assign to_hit = 1'b0;
`endif

  // Grant FSM: IDLE picks a winner, GRANT holds it until release, then back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx_q <= '0;
      gnt_oh_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_any) begin
            state     <= GRANT;
            gnt_idx_q <= sel_idx;
            gnt_oh_q  <= N_REQ'(1) << sel_idx;
          end
        end
        GRANT: begin
          if (rel_norm || to_hit) begin
            state     <= IDLE;
            gnt_oh_q  <= '0;
            ptr       <= gnt_idx_q + IDX_W'(1);
            timeout_q <= ~rel_norm;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign arb.gnt_vld = (state == GRANT);
  assign arb.gnt_idx = gnt_idx_q;
  assign arb.gnt_oh  = gnt_oh_q;
  assign arb.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb_8to3.sv
// Self-checking bench for rr_arb_8to3: directed scenarios plus random traffic,
// every cycle compared against a behavioural round-robin model.
// Timeout scenario is compiled in only when RR_ARB_TIMEOUT_EN is defined.
module tb_rr_arb_8to3;
  import rr_arb_pkg::*;

  localparam int TCYC = 4;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rr_arb_8to3_if bus ();

  rr_arb_8to3 #(.TIMEOUT_CYC(TCYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: who owns the bus, where the search starts, cycles held.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_held;
  bit m_to;

  int         g_idx[$];
  logic [7:0] g_oh[$];
  int         g_gap[$];
  int         exp27[4];
  bit         pv[6];
  bit         pt[6];

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_held  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_edge();
    int p;
    bit norm;
    bit force_rel;
    if (!rst_n) return;
    if (!m_busy) begin
      m_to = 1'b0;
      p = pick(bus.req, m_ptr);
      if (p >= 0) begin
        m_busy  = 1'b1;
        m_owner = p;
        m_held  = 1;
      end
    end else begin
      norm      = bus.done || !bus.req[m_owner];
      force_rel = TO_EN && !norm && (m_held == TCYC);
      if (norm || force_rel) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % 8;
        m_to   = force_rel;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ":vld"}, 32'(bus.gnt_vld), 32'(m_busy));
    chk({tag, ":idx"}, 32'(bus.gnt_idx), 32'(m_owner));
    chk({tag, ":oh"},  32'(bus.gnt_oh),  m_busy ? (32'd1 << m_owner) : 32'd0);
    chk({tag, ":to"},  32'(bus.timeout), 32'(m_to));
    chk({tag, ":onehot"}, 32'($countones(bus.gnt_oh) <= 1), 32'd1);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk_all(tag);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    #1;
    model_reset();
    chk_all("rst_async");
    repeat (2) tick("rst_hold");
    rst_n = 1'b1;
  endtask

  // Hold req constant, pulse done in every grant cycle, log grants and idle gaps.
  task automatic run_done_each(input logic [7:0] r, input int n, input string tag);
    int idle_run;
    idle_run = 0;
    g_idx.delete();
    g_oh.delete();
    g_gap.delete();
    bus.req  = r;
    bus.done = 1'b0;
    for (int c = 0; c < n * 4 && g_idx.size() < n; c++) begin
      tick(tag);
      if (bus.gnt_vld) begin
        g_idx.push_back(int'(bus.gnt_idx));
        g_oh.push_back(bus.gnt_oh);
        g_gap.push_back(idle_run);
        idle_run = 0;
        bus.done = 1'b1;
      end else begin
        idle_run++;
        bus.done = 1'b0;
      end
    end
    bus.done = 1'b0;
    chk({tag, ":count"}, 32'(g_idx.size()), 32'(n));
  endtask

  initial begin
    bus.req  = '0;
    bus.done = 1'b0;
    model_reset();
    #2;

    // Idle with no requests.
    do_reset();
    repeat (5) tick("idle");

    // Two requesters at the ends of the ring alternate.
    do_reset();
    exp27 = '{0, 7, 0, 7};
    run_done_each(8'h81, 4, "r81");
    for (int k = 0; k < g_idx.size(); k++) begin
      chk($sformatf("r81_idx%0d", k), 32'(g_idx[k]), 32'(exp27[k]));
      if (k > 0) chk($sformatf("r81_gap%0d", k), 32'(g_gap[k]), 32'd1);
    end

    // All requesters: full rotation with wrap back to 0.
    do_reset();
    run_done_each(8'hFF, 9, "rff");
    for (int k = 0; k < g_idx.size(); k++) begin
      chk($sformatf("rff_idx%0d", k), 32'(g_idx[k]), 32'(k % 8));
      chk($sformatf("rff_oh%0d", k), 32'(g_oh[k]), 32'd1 << (k % 8));
      if (k > 0) chk($sformatf("rff_gap%0d", k), 32'(g_gap[k]), 32'd1);
    end

    // Request withdrawal releases; search resumes above the old owner.
    do_reset();
    bus.req = 8'h08;
    tick("drop_gnt");
    chk("drop_first_idx", 32'(bus.gnt_idx), 32'd3);
    bus.req = 8'h00;
    tick("drop_rel");
    chk("drop_rel_vld", 32'(bus.gnt_vld), 32'd0);
    bus.req = 8'h09;
    tick("drop_next");
    chk("drop_next_vld", 32'(bus.gnt_vld), 32'd1);
    chk("drop_next_idx", 32'(bus.gnt_idx), 32'd0);

`ifdef RR_ARB_TIMEOUT_EN
    // Stuck owner gets forced off after TCYC cycles, then re-granted.
    do_reset();
    pv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    pt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bus.req = 8'h04;
    for (int k = 0; k < 6; k++) begin
      tick("to");
      chk($sformatf("to_vld%0d", k), 32'(bus.gnt_vld), 32'(pv[k]));
      chk($sformatf("to_pulse%0d", k), 32'(bus.timeout), 32'(pt[k]));
    end
    chk("to_regrant_idx", 32'(bus.gnt_idx), 32'd2);
`endif

    // Asynchronous reset in the middle of a grant.
    do_reset();
    bus.req = 8'h20;
    tick("ar_gnt");
    chk("ar_first_idx", 32'(bus.gnt_idx), 32'd5);
    tick("ar_hold");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("ar_async");
    chk("ar_vld0", 32'(bus.gnt_vld), 32'd0);
    chk("ar_oh0", 32'(bus.gnt_oh), 32'd0);
    repeat (2) tick("ar_in_rst");
    rst_n = 1'b1;
    tick("ar_regrant");
    chk("ar_regrant_vld", 32'(bus.gnt_vld), 32'd1);
    chk("ar_regrant_idx", 32'(bus.gnt_idx), 32'd5);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 8'($urandom);
      bus.done = ($urandom_range(0, 3) == 0);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
